ds_sys_sequencer: RTL and testbench
===================================

Name: ds_sys_sequencer

Overview:
Top-level sequencer for the image-downsampling processor and its single-port data memory (DM). It loads the input image from a byte stream (UART receiver) into DM, pulses the processor start, and hands DM ownership to the processor until it reports completion. It then streams the downsampled result out of DM over a valid/ready byte interface (UART transmitter). It owns the DM address, data and write-enable multiplexing in every phase.

Parameters:
ADDR_W, 19, DM address width (matches processor write_addr)
IMG_BYTES, 65536, input image size in bytes, loaded at DM address 0
OUT_BASE, 65536, DM address of first result byte
OUT_BYTES, 16384, result size in bytes
RUN_TIMEOUT, 4194304, max cycles in RUN before abort

Ports:
clk  in  1  system clock
RST  in  1  synchronous, active-high reset
go  in  1  start command; sampled only in IDLE and DONE
rx_valid  in  1  input byte valid (single-cycle strobe per byte)
rx_data  in  8  input image byte
tx_valid  out  1  result byte valid
tx_data  out  8  result byte
tx_ready  in  1  transmitter accepts byte
proc_start  out  1  one-cycle start pulse to processor
proc_status  in  1  processor done (level)
proc_mem  in  2  processor memory op: 00 none, 01 read, 10 write, 11 none
proc_addr  in  ADDR_W  processor DM address
proc_wdata  in  8  processor write data
proc_rdata  out  8  DM read data to processor (= dm_rdata, all phases)
dm_addr  out  ADDR_W  DM address
dm_wdata  out  8  DM write data
dm_we  out  1  DM write enable
dm_rdata  in  8  DM read data, registered: valid the cycle after address
phase  out  3  current state encoding
busy  out  1  high in LOAD..DUMP_TX
done  out  1  high in DONE
err  out  1  RUN timed out

Behaviour:
- States/encoding: IDLE=0, LOAD=1, START=2, RUN=3, DUMP_ADDR=4, DUMP_CAP=5, DUMP_TX=6, DONE=7.
- Reset: state IDLE; load_cnt, dump_cnt, run_cnt = 0; tx_data = 0; err = 0. All outputs 0.
- IDLE: go=1 -> LOAD, load_cnt=0.
- LOAD, per-byte write:
  - When rx_valid=1: dm_we=1, dm_addr=load_cnt, dm_wdata=rx_data, all combinational in the same cycle; load_cnt++.
  - On the byte where load_cnt==IMG_BYTES-1 -> START.
  - rx_valid=0: dm_we=0, no change.
- START: proc_start=1 for exactly one cycle; run_cnt=0 -> RUN.
- RUN, DM passthrough and termination:
  - dm_addr=proc_addr, dm_wdata=proc_wdata, dm_we=(proc_mem==2'b10).
  - run_cnt++ each cycle.
  - proc_status=1 -> DUMP_ADDR, dump_cnt=0. Takes priority over timeout in the same cycle.
  - Else run_cnt==RUN_TIMEOUT-1 -> DONE with err=1.
- DUMP_ADDR: dm_addr=OUT_BASE+dump_cnt (ADDR_W wrap), dm_we=0 -> DUMP_CAP.
- DUMP_CAP: dm_addr held; tx_data<=dm_rdata at end of cycle -> DUMP_TX.
- DUMP_TX:
  - tx_valid=1; tx_data stable until accepted.
  - On tx_valid&&tx_ready: if dump_cnt==OUT_BYTES-1 -> DONE, else dump_cnt++ -> DUMP_ADDR.
  - tx_valid is 0 in all other states. Minimum 3 cycles per result byte.
- DONE: done=1, busy=0. go=1 -> LOAD, err cleared, load_cnt=0.
- Ignored inputs:
  - go is ignored in LOAD..DUMP_TX.
  - rx_valid is ignored (byte dropped, no write) outside LOAD.
  - proc_mem is ignored outside RUN.
  - proc_status is ignored outside RUN.
- dm_we is 0 outside LOAD/RUN. dm_addr/dm_wdata are 0 in IDLE, START and DONE.
- Reset asserted mid-operation: next cycle IDLE, counters cleared, no further writes or tx. A partially transmitted byte is abandoned (tx_valid drops).
- Counters are ADDR_W+1 bits (run_cnt 32 bits); no wrap within legal parameter ranges.

Test Plan:
Use IMG_BYTES=16, OUT_BASE=16, OUT_BYTES=4, RUN_TIMEOUT=100, behavioural DM with 1-cycle read.
1. Reset: RST=1 for 2 cycles with go=1 -> phase=0, all outputs 0. After release, go=1 -> phase=1 next cycle.
2. Load: 16 bytes 0x10..0x1F with random 0-3 cycle gaps -> DM[0..15]=0x10..0x1F. proc_start high exactly one cycle, then phase=3. A stray rx_valid in RUN causes no write.
3. Run passthrough:
   - proc_mem=10, proc_addr=16, proc_wdata=0xAB -> dm_we=1, dm_addr=16 same cycle.
   - proc_mem=01 -> dm_we=0; proc_rdata returns DM data next cycle.
4. Dump with backpressure: DM[16..19]=A0..A3, proc_status=1, tx_ready toggling -> tx_data sequence A0,A1,A2,A3, each stable while tx_ready=0. done=1, err=0 after 4th handshake.
5. Timeout: proc_status held 0 -> DONE exactly 100 cycles after entering RUN, err=1, tx_valid never high. Then go -> LOAD with err=0.
6. Reset mid-LOAD after 5 bytes -> IDLE. go during LOAD before the reset has no effect. A new go reloads starting at DM address 0.

Source files
------------

// File: rtl/ds_sys_sequencer.sv
// Sequencer that owns the image-downsampler's data memory: load the image from a byte
// stream, hand the memory to the processor, then stream the result out on a valid/ready port.
module ds_sys_sequencer #(
  parameter int ADDR_W      = 19,
  parameter int IMG_BYTES   = 65536,
  parameter int OUT_BASE    = 65536,
  parameter int OUT_BYTES   = 16384,
  parameter int RUN_TIMEOUT = 4194304
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              go,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              proc_start,
  input  logic              proc_status,
  input  logic [1:0]        proc_mem,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_wdata,
  output logic [7:0]        proc_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_wdata,
  output logic              dm_we,
  input  logic [7:0]        dm_rdata,
  output logic [2:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Output handshake: a result byte moves when tx_valid && tx_ready on a rising edge;
  // tx_valid is only raised in DUMP_TX and tx_data is held constant until that handshake.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_DUMP_ADDR = 3'd4,
    S_DUMP_CAP  = 3'd5,
    S_DUMP_TX   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [ADDR_W:0] LOAD_LAST = (ADDR_W+1)'(IMG_BYTES - 1);
  localparam logic [ADDR_W:0] DUMP_LAST = (ADDR_W+1)'(OUT_BYTES - 1);
  localparam logic [31:0]     RUN_LAST  = 32'(RUN_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_load_cnt, r_dump_cnt;
  logic [31:0]       r_run_cnt;
  logic [7:0]        r_tx_data;
  logic              r_err;
  logic [ADDR_W-1:0] w_dump_addr;

  assign w_dump_addr = OUT_BASE_A + r_dump_cnt[ADDR_W-1:0];

  always_comb begin
    w_next     = r_state;
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_we      = 1'b0;
    proc_start = 1'b0;
    tx_valid   = 1'b0;
    case (r_state)
      S_IDLE: if (go) w_next = S_LOAD;
      S_LOAD: begin
        dm_addr = r_load_cnt[ADDR_W-1:0];
        if (rx_valid) begin
          dm_we    = 1'b1;
          dm_wdata = rx_data;
          if (r_load_cnt == LOAD_LAST) w_next = S_START;
        end
      end
      S_START: begin
        proc_start = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: begin
        dm_addr  = proc_addr;
        dm_wdata = proc_wdata;
        dm_we    = (proc_mem == 2'b10);
        // Completion wins over a timeout landing on the same cycle.
        if (proc_status)                 w_next = S_DUMP_ADDR;
        else if (r_run_cnt == RUN_LAST)  w_next = S_DONE;
      end
      S_DUMP_ADDR: begin
        dm_addr = w_dump_addr;
        w_next  = S_DUMP_CAP;
      end
      S_DUMP_CAP: begin
        dm_addr = w_dump_addr;
        w_next  = S_DUMP_TX;
      end
      S_DUMP_TX: begin
        dm_addr  = w_dump_addr;
        tx_valid = 1'b1;
        if (tx_ready) w_next = (r_dump_cnt == DUMP_LAST) ? S_DONE : S_DUMP_ADDR;
      end
      S_DONE: if (go) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_load_cnt <= '0;
      r_dump_cnt <= '0;
      r_run_cnt  <= '0;
      r_tx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (go) r_load_cnt <= '0;
        S_LOAD: if (rx_valid) r_load_cnt <= r_load_cnt + 1'b1;
        S_START: r_run_cnt <= '0;
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          if (proc_status)                r_dump_cnt <= '0;
          else if (r_run_cnt == RUN_LAST) r_err      <= 1'b1;
        end
        // DM read data is registered, so it is captured one cycle after the address.
        S_DUMP_CAP: r_tx_data <= dm_rdata;
        S_DUMP_TX: if (tx_ready && (r_dump_cnt != DUMP_LAST)) r_dump_cnt <= r_dump_cnt + 1'b1;
        S_DONE: if (go) begin
          r_err      <= 1'b0;
          r_load_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign proc_rdata = dm_rdata;
  assign phase      = r_state;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;

endmodule

// File: tb/tb_ds_sys_sequencer.sv
// Directed bench for ds_sys_sequencer: behavioural DM, cycle-level reference model with a
// per-cycle compare process, plus literal checks on the key scenarios.
module tb_ds_sys_sequencer;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          go = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic          proc_start;
  logic          proc_status = 1'b0;
  logic [1:0]    proc_mem = 2'b00;
  logic [AW-1:0] proc_addr = '0;
  logic [7:0]    proc_wdata = '0;
  logic [7:0]    proc_rdata;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_wdata;
  logic          dm_we;
  logic [7:0]    dm_rdata = '0;
  logic [2:0]    phase;
  logic          busy, done, err;

  ds_sys_sequencer #(.ADDR_W(AW), .IMG_BYTES(16), .OUT_BASE(16), .OUT_BYTES(4),
                     .RUN_TIMEOUT(100)) dut (
    .clk(clk), .RST(RST), .go(go), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .proc_start(proc_start), .proc_status(proc_status), .proc_mem(proc_mem),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
    .phase(phase), .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural single-port DM, read-first, 1-cycle read latency
  logic [7:0] dm [0:63];
  always @(posedge clk) begin
    if (dm_we) dm[dm_addr[5:0]] <= dm_wdata;
    dm_rdata <= dm[dm_addr[5:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_tx  = 0;
  logic chk_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: phase number, bytes loaded, result index, cycles spent running
  int         m_ph = 0;
  int         m_load = 0;
  int         m_dump = 0;
  int         m_run = 0;
  logic [7:0] m_tx = '0;
  logic       m_err = 1'b0;
  logic [7:0] ref_mem [0:63];
  initial for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
  initial for (int i = 0; i < 64; i++) dm[i] = 8'h00;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase", 32'(phase), 32'(m_ph));
      chk("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 6));
      chk("done", 32'(done), 32'(m_ph == 7));
      chk("err", 32'(err), 32'(m_err));
      chk("proc_start", 32'(proc_start), 32'(m_ph == 2));
      chk("tx_valid", 32'(tx_valid), 32'(m_ph == 6));
      chk("tx_data", 32'(tx_data), 32'(m_tx));
      chk("proc_rdata", 32'(proc_rdata), 32'(dm_rdata));
      chk("dm_we", 32'(dm_we), 32'((m_ph == 1 && rx_valid) || (m_ph == 3 && proc_mem == 2'b10)));
      if (m_ph == 1 && rx_valid) begin
        chk("load_addr", 32'(dm_addr), 32'(m_load));
        chk("load_wdata", 32'(dm_wdata), 32'(rx_data));
      end else if (m_ph == 3) begin
        chk("run_addr", 32'(dm_addr), 32'(proc_addr));
        chk("run_wdata", 32'(dm_wdata), 32'(proc_wdata));
      end else if (m_ph == 4 || m_ph == 5) begin
        chk("dump_addr", 32'(dm_addr), 32'(16 + m_dump));
      end else if (m_ph == 0 || m_ph == 2 || m_ph == 7) begin
        chk("idle_addr", 32'(dm_addr), 32'd0);
        chk("idle_wdata", 32'(dm_wdata), 32'd0);
      end
      if (tx_valid && tx_ready && !RST) begin
        n_tx <= n_tx + 1;
        if (exp_q.size() == 0) chk("tx_extra", 32'(tx_data), 32'hFFFF_FFFF);
        else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    // expected memory contents follow the writes the rules say must happen
    if (m_ph == 1 && rx_valid) ref_mem[m_load[5:0]] <= rx_data;
    if (m_ph == 3 && proc_mem == 2'b10) ref_mem[proc_addr[5:0]] <= proc_wdata;
    if (RST) begin
      m_ph <= 0; m_load <= 0; m_dump <= 0; m_run <= 0; m_tx <= '0; m_err <= 1'b0;
    end else begin
      case (m_ph)
        0: if (go) begin m_ph <= 1; m_load <= 0; end
        1: if (rx_valid) begin
          m_load <= m_load + 1;
          if (m_load == 15) m_ph <= 2;
        end
        2: begin m_ph <= 3; m_run <= 0; end
        3: begin
          m_run <= m_run + 1;
          if (proc_status) begin m_ph <= 4; m_dump <= 0; end
          else if (m_run == 99) begin m_ph <= 7; m_err <= 1'b1; end
        end
        4: m_ph <= 5;
        5: begin m_tx <= ref_mem[16 + m_dump]; m_ph <= 6; end
        6: if (tx_ready) begin
          if (m_dump == 3) m_ph <= 7;
          else begin m_dump <= m_dump + 1; m_ph <= 4; end
        end
        default: if (go) begin m_ph <= 1; m_err <= 1'b0; m_load <= 0; end
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1. reset with go held high
    RST = 1'b1; go = 1'b1;
    tick(); chk_en = 1'b1; tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_outs", {tx_valid, dm_we, busy, done, err, proc_start}, 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    RST = 1'b0;
    tick();
    chk("go_load", 32'(phase), 32'd1);
    go = 1'b0;

    // 2. load with random gaps
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), $urandom_range(0, 3));
    chk("start_phase", 32'(phase), 32'd2);
    chk("start_pulse", 32'(proc_start), 32'd1);
    tick();
    chk("run_phase", 32'(phase), 32'd3);
    chk("start_gone", 32'(proc_start), 32'd0);
    for (int i = 0; i < 16; i++) chk("dm_load", 32'(dm[i]), 32'(8'h10 + 8'(i)));
    rx_valid = 1'b1; rx_data = 8'h55;
    #1 chk("stray_rx_we", 32'(dm_we), 32'd0);
    tick();
    rx_valid = 1'b0;

    // 3. run passthrough
    proc_mem = 2'b10; proc_addr = 19'd16; proc_wdata = 8'hAB;
    #1 chk("pw_we", 32'(dm_we), 32'd1);
    chk("pw_addr", 32'(dm_addr), 32'd16);
    tick();
    proc_mem = 2'b01; proc_wdata = 8'h00;
    #1 chk("pr_we", 32'(dm_we), 32'd0);
    tick();
    chk("pr_rdata", 32'(proc_rdata), 32'hAB);
    for (int i = 0; i < 4; i++) begin
      proc_mem = 2'b10; proc_addr = 19'(16 + i); proc_wdata = 8'hA0 + 8'(i);
      tick();
      exp_q.push_back(8'hA0 + 8'(i));
    end
    proc_mem = 2'b00; proc_status = 1'b1;
    tick();
    proc_status = 1'b0;
    chk("dump_phase", 32'(phase), 32'd4);

    // 4. dump with toggling ready
    n = 0;
    while (!done && n < 200) begin
      tx_ready = ~tx_ready;
      tick();
      n++;
    end
    tx_ready = 1'b0;
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_err", 32'(err), 32'd0);
    chk("dump_count", 32'(n_tx), 32'd4);
    chk("dump_left", 32'(exp_q.size()), 32'd0);

    // 5. timeout
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 0);
    tick();
    chk("to_run", 32'(phase), 32'd3);
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd100);
    chk("to_err", 32'(err), 32'd1);
    go = 1'b1; tick(); go = 1'b0;
    chk("to_reload", 32'(phase), 32'd1);
    chk("to_errclr", 32'(err), 32'd0);

    // 6. reset mid-load, go ignored while loading
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1);
    go = 1'b1; tick(); go = 1'b0;
    chk("go_ignored", 32'(phase), 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("mid_rst", 32'(phase), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    go = 1'b1; tick(); go = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h77;
    #1 chk("reload_addr", 32'(dm_addr), 32'd0);
    tick();
    rx_valid = 1'b0;
    chk("reload_dm0", 32'(dm[0]), 32'h77);
    chk("keep_dm5", 32'(dm[5]), 32'h25);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
